// File: rtl/fft_frame_loader.sv
// Streams one frame of samples into the FFT core's memory in bit-reversed order,
// zero-pads short frames, starts the FFT and waits for completion. Optional: FFT_LOADER_PRESCALE_EN.
module fft_frame_loader #(
   parameter int unsigned N_POINTS    = 32,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned PRESCALE_SH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_real,
   input  logic [DATA_W-1:0] s_imag,
   input  logic              s_last,
   output logic              load_data_write,
   output logic [ADDR_W-1:0] load_data_addr,
   output logic [DATA_W-1:0] data_real_out,
   output logic [DATA_W-1:0] data_imag_out,
   output logic              fft_start,
   input  logic              fft_done,
   output logic              busy,
   output logic              short_frame
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

   typedef enum logic [1:0] {LOAD, PAD, START, WAIT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] index, index_nxt;
   logic              start_wait, start_wait_nxt;
   logic              fft_done_q;
   logic              write_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] real_nxt, imag_nxt;
   logic              start_nxt, short_nxt;
   logic [DATA_W-1:0] samp_real, samp_imag;
   logic              take;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
      logic [ADDR_W-1:0] r;
      for (int i = 0; i < int'(ADDR_W); i++) r[ADDR_W-1-i] = v[i];
      return r;
   endfunction

`ifdef FFT_LOADER_PRESCALE_EN
   // Arithmetic shift gives butterfly headroom; truncates toward minus infinity.
   assign samp_real = DATA_W'($signed(s_real) >>> PRESCALE_SH);
   assign samp_imag = DATA_W'($signed(s_imag) >>> PRESCALE_SH);
`else
   localparam int unsigned unused_prescale_sh = PRESCALE_SH;
   assign samp_real = s_real;
   assign samp_imag = s_imag;
`endif

   assign take = s_valid && s_ready;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt      = state;
      index_nxt      = index;
      start_wait_nxt = 1'b0;
      write_nxt      = 1'b0;
      addr_nxt       = load_data_addr;
      real_nxt       = data_real_out;
      imag_nxt       = data_imag_out;
      start_nxt      = 1'b0;
      short_nxt      = short_frame;
      case (state)
         LOAD: begin
            if (take) begin
               write_nxt = 1'b1;
               addr_nxt  = bitrev(index);
               real_nxt  = samp_real;
               imag_nxt  = samp_imag;
               if (index == LAST_IDX) begin
                  state_nxt = START;
                  short_nxt = 1'b0;
               end else begin
                  index_nxt = index + ADDR_W'(1);
                  if (s_last) begin
                     state_nxt = PAD;
                     short_nxt = 1'b1;
                  end
               end
            end
         end
         PAD: begin
            write_nxt = 1'b1;
            addr_nxt  = bitrev(index);
            real_nxt  = '0;
            imag_nxt  = '0;
            if (index == LAST_IDX) state_nxt = START;
            else                   index_nxt = index + ADDR_W'(1);
         end
         START: begin
            // One idle cycle lets the final write land before the FFT starts.
            if (!start_wait) begin
               start_wait_nxt = 1'b1;
            end else begin
               start_nxt = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (fft_done && !fft_done_q) begin
               state_nxt = LOAD;
               index_nxt = '0;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= LOAD;
         index           <= '0;
         start_wait      <= 1'b0;
         fft_done_q      <= 1'b0;
         s_ready         <= 1'b0;
         load_data_write <= 1'b0;
         load_data_addr  <= '0;
         data_real_out   <= '0;
         data_imag_out   <= '0;
         fft_start       <= 1'b0;
         busy            <= 1'b0;
         short_frame     <= 1'b0;
      end else begin
         state           <= state_nxt;
         index           <= index_nxt;
         start_wait      <= start_wait_nxt;
         fft_done_q      <= fft_done;
         s_ready         <= (state_nxt == LOAD);
         load_data_write <= write_nxt;
         load_data_addr  <= addr_nxt;
         data_real_out   <= real_nxt;
         data_imag_out   <= imag_nxt;
         fft_start       <= start_nxt;
         busy            <= (state_nxt != LOAD);
         short_frame     <= short_nxt;
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: full, short, gappy and reset-interrupted frames.
module tb_fft_frame_loader;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 5;
   localparam int unsigned NP = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid, s_ready, s_last;
   logic [DW-1:0] s_real, s_imag;
   logic          load_data_write;
   logic [AW-1:0] load_data_addr;
   logic [DW-1:0] data_real_out, data_imag_out;
   logic          fft_start, fft_done, busy, short_frame;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fft_frame_loader dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
      .load_data_write(load_data_write), .load_data_addr(load_data_addr),
      .data_real_out(data_real_out), .data_imag_out(data_imag_out),
      .fft_start(fft_start), .fft_done(fft_done), .busy(busy), .short_frame(short_frame)
   );

   // Write/start monitor sampled on the falling edge.
   int cyc = 0, wr_cnt = 0, dup_cnt = 0, start_cnt = 0;
   int first_wr_cyc = 0, last_wr_cyc = 0, start_cyc = 0, first_addr = -1, short_at_start = -1;
   int mem_r [NP];
   int mem_i [NP];
   bit seen  [NP];
   int addr_seq [64];

   always @(negedge clk) begin
      cyc++;
      if (load_data_write === 1'b1) begin
         if (wr_cnt == 0) begin
            first_wr_cyc = cyc;
            first_addr   = int'(load_data_addr);
         end
         if (wr_cnt < 64) addr_seq[wr_cnt] = int'(load_data_addr);
         if (seen[load_data_addr]) dup_cnt++;
         seen[load_data_addr]  = 1'b1;
         mem_r[load_data_addr] = int'($signed(data_real_out));
         mem_i[load_data_addr] = int'($signed(data_imag_out));
         last_wr_cyc = cyc;
         wr_cnt++;
      end
      if (fft_start === 1'b1) begin
         start_cnt++;
         start_cyc      = cyc;
         short_at_start = int'(short_frame);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int brev(input int v);
      int r = 0;
      for (int b = 0; b < int'(AW); b++) r = (r << 1) | ((v >> b) & 1);
      return r;
   endfunction

   function automatic int scale(input int x);
`ifdef FFT_LOADER_PRESCALE_EN
      return x >>> 2;
`else
      return x;
`endif
   endfunction

   task automatic clear_mon();
      wr_cnt = 0; dup_cnt = 0; start_cnt = 0; first_addr = -1; short_at_start = -1;
      for (int k = 0; k < int'(NP); k++) begin
         seen[k] = 1'b0; mem_r[k] = 12345; mem_i[k] = 12345;
      end
   endtask

   task automatic send(input int r, input int im, input bit last);
      int budget = 200;
      s_valid = 1'b1; s_real = DW'(r); s_imag = DW'(im); s_last = last;
      while (!s_ready && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (!s_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_start();
      int budget = 200;
      while (start_cnt == 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      chk("start_seen", int'(start_cnt > 0), 1);
   endtask

   task automatic done_pulse();
      fft_done = 1'b1;
      @(posedge clk); #1;
      fft_done = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, int'(s_ready), 0);
      chk({tag, "_write"},   int'(load_data_write), 0);
      chk({tag, "_addr"},    int'(load_data_addr), 0);
      chk({tag, "_data"},    int'({data_real_out, data_imag_out}), 0);
      chk({tag, "_start"},   int'(fft_start), 0);
      chk({tag, "_busy"},    int'(busy), 0);
      chk({tag, "_short"},   int'(short_frame), 0);
   endtask

   typedef struct { int idx; int addr; } addr_vec_t;
   typedef struct { int in_r; int in_i; int exp_r; int exp_i; } ps_vec_t;

   initial begin
      addr_vec_t av [6];
      ps_vec_t   pv [2];
      int bad;

      av[0] = '{1, 16}; av[1] = '{3, 24}; av[2] = '{5, 20};
      av[3] = '{31, 31}; av[4] = '{0, 0}; av[5] = '{10, 10};
`ifdef FFT_LOADER_PRESCALE_EN
      pv[0] = '{-7, 13, -2, 3}; pv[1] = '{-1, 4, -1, 1};
`else
      pv[0] = '{-7, 13, -7, 13}; pv[1] = '{-1, 4, -1, 4};
`endif

      rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; fft_done = 1'b0;
      #12;
      chk_reset_outputs("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      chk("ready_before_edge", int'(s_ready), 0);
      @(posedge clk); #1;
      chk("ready_after_release", int'(s_ready), 1);

      // Full frame, s_valid held high.
      clear_mon();
      for (int i = 0; i < int'(NP); i++) send(i, -i, i == int'(NP) - 1);
      s_valid = 1'b0;
      chk("ready_after_last", int'(s_ready), 0);
      chk("busy_after_last", int'(busy), 1);
      wait_start();
      repeat (3) @(posedge clk); #1;
      chk("full_start_cnt", start_cnt, 1);
      chk("full_start_delay", start_cyc - last_wr_cyc, 2);
      chk("full_wr_cnt", wr_cnt, 32);
      chk("full_dups", dup_cnt, 0);
      chk("full_short", int'(short_frame), 0);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("full_real_idx%0d", av[k].idx), mem_r[av[k].addr], scale(av[k].idx));
         chk($sformatf("full_imag_idx%0d", av[k].idx), mem_i[av[k].addr], scale(-av[k].idx));
      end
      chk("wait_no_ready", int'(s_ready), 0);
      done_pulse();
      chk("ready_after_done", int'(s_ready), 1);

      // Short frame ending at index 9; fft_done held high before WAIT entry.
      clear_mon();
      for (int i = 0; i < 10; i++) send(i + 100, i, i == 9);
      s_valid = 1'b0;
      chk("short_set", int'(short_frame), 1);
      fft_done = 1'b1;
      wait_start();
      repeat (5) @(posedge clk); #1;
      chk("short_wr_cnt", wr_cnt, 32);
      chk("short_dups", dup_cnt, 0);
      chk("short_wr_span", last_wr_cyc - first_wr_cyc, 31);
      chk("short_at_start", short_at_start, 1);
      bad = 0;
      for (int i = 10; i < int'(NP); i++)
         if (mem_r[brev(i)] != 0 || mem_i[brev(i)] != 0) bad++;
      chk("pad_zero", bad, 0);
      chk("done_level_ignored", int'(s_ready), 0);
      fft_done = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("done_low_wait", int'(s_ready), 0);
      fft_done = 1'b1;
      @(posedge clk); #1;
      chk("done_rise_ready", int'(s_ready), 1);
      fft_done = 1'b0;

      // Gappy source: one idle cycle between samples.
      clear_mon();
      for (int i = 0; i < int'(NP); i++) begin
         send(i, i, i == int'(NP) - 1);
         s_valid = 1'b0;
         @(posedge clk); #1;
      end
      wait_start();
      repeat (3) @(posedge clk); #1;
      chk("gap_first_addr", first_addr, 0);
      chk("gap_wr_cnt", wr_cnt, 32);
      chk("gap_dups", dup_cnt, 0);
      bad = 0;
      for (int k = 0; k < int'(NP); k++) if (addr_seq[k] != brev(k)) bad++;
      chk("gap_order", bad, 0);
      bad = 0;
      for (int k = 0; k < int'(NP); k++) if (mem_r[brev(k)] != scale(k)) bad++;
      chk("gap_data", bad, 0);
      chk("gap_short_cleared", short_at_start, 0);
      done_pulse();

      // Reset after 12 samples.
      clear_mon();
      for (int i = 0; i < 12; i++) send(i + 1, i, 1'b0);
      s_valid = 1'b0;
      chk("pre_reset_write", int'(load_data_write), 1);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      for (int i = 0; i < int'(NP) - 1; i++) send(i + 1, 0, 1'b0);
      s_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("rst_first_addr", first_addr, 0);
      chk("rst_no_early_start", start_cnt, 0);
      send(32, 0, 1'b0);
      s_valid = 1'b0;
      wait_start();
      chk("rst_wr_cnt", wr_cnt, 32);
      done_pulse();

      // Sample scaling path.
      for (int k = 0; k < 2; k++) begin
         send(pv[k].in_r, pv[k].in_i, 1'b0);
         s_valid = 1'b0;
         chk($sformatf("scale_real_%0d", k), int'($signed(data_real_out)), pv[k].exp_r);
         chk($sformatf("scale_imag_%0d", k), int'($signed(data_imag_out)), pv[k].exp_i);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
